// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle radix-2 non-restoring integer divider.
// Handles signed (two's-complement, truncating toward zero) and unsigned
// operands. It produces a quotient on LO and a remainder on HI. A zero
// divisor produces LO = all ones, HI = X and sets div_by_zero.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ZERO_R   = {(WIDTH+1){1'b0}};

  // Control state
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Operands captured at acceptance; later input changes cannot disturb them
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sgn_q, sgn_d;
  // Datapath: divisor magnitude, partial remainder (one extra sign bit), quotient
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  // Registered outputs
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Combinational helpers
  logic             x_neg_s, y_neg_s;
  logic [WIDTH:0]   b_ext_s, r_shift_s, r_step_s;
  logic [WIDTH-1:0] rem_fix_s, quo_final_s, rem_final_s;

  assign x_neg_s   = sgn_q & x_q[WIDTH-1];
  assign y_neg_s   = sgn_q & y_q[WIDTH-1];
  assign b_ext_s   = {1'b0, b_q};
  // {R,Q} shifted left one bit: R picks up the quotient MSB
  assign r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  // Non-restoring step: subtract while R is non-negative, add back otherwise.
  // Arithmetic is modulo 2^(WIDTH+1); the true result always fits there.
  assign r_step_s  = r_q[WIDTH] ? (r_shift_s + b_ext_s) : (r_shift_s - b_ext_s);
  // Final correction: a negative remainder gets |Y| added back (result < |Y|)
  assign rem_fix_s   = r_q[WIDTH] ? (r_q[WIDTH-1:0] + b_q) : r_q[WIDTH-1:0];
  assign quo_final_s = neg_quo_q ? (ZERO_W - q_q) : q_q;
  assign rem_final_s = neg_rem_q ? (ZERO_W - rem_fix_s) : rem_fix_s;

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign LO          = lo_q;
  assign HI          = hi_q;

  // Next-state logic for FSM, datapath and output registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    sgn_d     = sgn_q;
    b_d       = b_q;
    r_d       = r_q;
    q_d       = q_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = X;
          y_d     = Y;
          sgn_d   = is_signed;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        neg_quo_d = x_neg_s ^ y_neg_s;
        neg_rem_d = x_neg_s;
        b_d       = y_neg_s ? (ZERO_W - y_q) : y_q;
        q_d       = x_neg_s ? (ZERO_W - x_q) : x_q;
        r_d       = ZERO_R;
        cnt_d     = CNT_ZERO;
        dz_d      = (y_q == ZERO_W);
        // A zero divisor skips ITER but still spends one cycle in FIX.
        // This keeps the zero-divisor done three cycles after acceptance.
        if (y_q == ZERO_W) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        r_d   = r_step_s;
        q_d   = {q_q[WIDTH-2:0], ~r_step_s[WIDTH]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (dz_q) begin
          lo_d  = ONES_W;
          hi_d  = x_q;
          dbz_d = 1'b1;
        end else begin
          lo_d  = quo_final_s;
          hi_d  = rem_final_s;
          dbz_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      x_q       <= ZERO_W;
      y_q       <= ZERO_W;
      sgn_q     <= 1'b0;
      b_q       <= ZERO_W;
      r_q       <= ZERO_R;
      q_q       <= ZERO_W;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      lo_q      <= ZERO_W;
      hi_q      <= ZERO_W;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sgn_q     <= sgn_d;
      b_q       <= b_d;
      r_q       <= r_d;
      q_q       <= q_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit (WIDTH = 32) against a plain-arithmetic model.
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start_i;
  logic        sgn_i;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] lo;
  logic [31:0] hi;

  int total = 0;
  int bad   = 0;

  div_seq_unit #(.WIDTH(32)) dut (
    .clock(clk), .clear(clr), .start(start_i), .is_signed(sgn_i),
    .X(x_i), .Y(y_i), .busy(busy), .done(done), .div_by_zero(dbz),
    .LO(lo), .HI(hi)
  );

  always #5 clk = ~clk;

  // Reference: integer division truncating toward zero, zero-divisor convention.
  function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] elo, output logic [31:0] ehi,
                                output logic edz, output int elat);
    longint a, b, qv, rv;
    if (y == 32'd0) begin
      elo = 32'hFFFF_FFFF; ehi = x; edz = 1'b1; elat = 3;
    end else begin
      if (s) begin
        a = longint'($signed(x)); b = longint'($signed(y));
      end else begin
        a = longint'({32'd0, x}); b = longint'({32'd0, y});
      end
      qv = a / b; rv = a % b;
      elo = qv[31:0]; ehi = rv[31:0]; edz = 1'b0; elat = 35;
    end
  endfunction

  // Issue one operation; return latency (cycle index of done, -1 on timeout),
  // number of cycles busy was low before/at done, and captured results.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input bit disturb, output int lat, output int bbad,
                       output logic [31:0] rlo, output logic [31:0] rhi, output logic rdz);
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    sgn_i = s; x_i = x; y_i = y; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1; bbad = 0;
    for (int c = 1; c <= 100; c++) begin
      if (busy !== 1'b1) bbad++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (disturb && c == 5) begin
        start_i = 1'b1; x_i = $urandom; y_i = $urandom; sgn_i = ~s;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    rlo = lo; rhi = hi; rdz = dbz;
  endtask

  task automatic test_reset;
    clr = 1'b1; start_i = 1'b0; sgn_i = 1'b0; x_i = 32'd0; y_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, dbz} !== 3'b000 || lo !== 32'd0 || hi !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b lo=%h hi=%h want all 0",
               busy, done, dbz, lo, hi);
    end
    clr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic        ts [12];
    logic [31:0] tx [12];
    logic [31:0] ty [12];
    logic [31:0] rlo, rhi, elo, ehi;
    logic        rdz, edz;
    int          lat, bbad, elat;
    ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tx = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    ty = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd9, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 12; i++) begin
      model(ts[i], tx[i], ty[i], elo, ehi, edz, elat);
      do_op(ts[i], tx[i], ty[i], 1'b0, lat, bbad, rlo, rhi, rdz);
      total++;
      if (lat !== elat || bbad !== 0) begin
        bad++;
        $display("FAIL dir%0d_timing: got lat=%0d busy_low=%0d want lat=%0d busy_low=0",
                 i, lat, bbad, elat);
      end
      total++;
      if (rlo !== elo || rhi !== ehi || rdz !== edz) begin
        bad++;
        $display("FAIL dir%0d_result: got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b",
                 i, rlo, rhi, rdz, elo, ehi, edz);
      end
    end
    // Spot-check the literal vector for 100/7 and that results hold while idle
    do_op(1'b1, 32'd100, 32'd7, 1'b0, lat, bbad, rlo, rhi, rdz);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (lo !== 32'd14 || hi !== 32'd2 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_100_7: got lo=%h hi=%h done=%b busy=%b want lo=e hi=2 done=0 busy=0",
               lo, hi, done, busy);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] rlo, rhi;
    logic        rdz;
    int          lat, bbad;
    do_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, lat, bbad, rlo, rhi, rdz);
    total++;
    if (lat !== 3 || bbad !== 0 || rdz !== 1'b1 || rlo !== 32'hFFFF_FFFF || rhi !== 32'h1234_5678) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d busy_low=%0d dz=%b lo=%h hi=%h want 3 0 1 ffffffff 12345678",
               lat, bbad, rdz, rlo, rhi);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dbz !== 1'b1) begin
      bad++;
      $display("FAIL dz_held: got %b want 1", dbz);
    end
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, lat, bbad, rlo, rhi, rdz);
    total++;
    if (rdz !== 1'b0 || rlo !== 32'hFFFF_FFF2 || rhi !== 32'hFFFF_FFFE || lat !== 35) begin
      bad++;
      $display("FAIL dz_cleared: got dz=%b lo=%h hi=%h lat=%0d want 0 fffffff2 fffffffe 35",
               rdz, rlo, rhi, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y, rlo, rhi, elo, ehi;
    logic        s, rdz, edz;
    int          lat, bbad, elat, k;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0)      y = 32'd0;
      else if (k < 4)  y = 32'($urandom_range(1, 20));
      else if (k == 4) y = 32'hFFFF_FFFF;
      else             y = $urandom;
      if (k == 5) x = 32'h8000_0000;
      model(s, x, y, elo, ehi, edz, elat);
      do_op(s, x, y, (i % 3) == 0, lat, bbad, rlo, rhi, rdz);
      total++;
      if (lat !== elat || bbad !== 0 || rlo !== elo || rhi !== ehi || rdz !== edz) begin
        bad++;
        $display("FAIL rand%0d s=%b x=%h y=%h: got lat=%0d bl=%0d lo=%h hi=%h dz=%b want lat=%0d bl=0 lo=%h hi=%h dz=%b",
                 i, s, x, y, lat, bbad, rlo, rhi, rdz, elat, elo, ehi, edz);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rlo, rhi, elo, ehi;
    logic        rdz, edz;
    int          lat, bbad, elat;
    do_op(1'b0, 32'd1000, 32'd3, 1'b0, lat, bbad, rlo, rhi, rdz);
    // Now in the DONE cycle: request next op immediately and keep it up
    sgn_i = 1'b1; x_i = 32'hFFFF_FC18; y_i = 32'd33; start_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_not_taken_in_done: got busy=%b want 0", busy);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    model(1'b1, 32'hFFFF_FC18, 32'd33, elo, ehi, edz, elat);
    total++;
    if (lat !== elat || lo !== elo || hi !== ehi || dbz !== edz) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h dz=%b want lat=%0d lo=%h hi=%h dz=%b",
               lat, lo, hi, dbz, elat, elo, ehi, edz);
    end
  endtask

  task automatic test_clear_mid;
    logic [31:0] rlo, rhi;
    logic        rdz;
    int          lat, bbad, ndone, nbusy;
    sgn_i = 1'b1; x_i = 32'd123456; y_i = 32'd789; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin
        start_i = 1'b1; x_i = 32'd55; y_i = 32'd5;
      end else begin
        start_i = 1'b0;
      end
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if ({busy, done, dbz} !== 3'b000 || lo !== 32'd0 || hi !== 32'd0) begin
      bad++;
      $display("FAIL clear_mid: got busy=%b done=%b dz=%b lo=%h hi=%h want all 0",
               busy, done, dbz, lo, hi);
    end
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL clear_no_done: got %0d done pulses want 0", ndone);
    end
    // clear beats start in the same cycle
    clr = 1'b1; start_i = 1'b1; x_i = 32'd9; y_i = 32'd2;
    @(posedge clk); #1;
    clr = 1'b0; start_i = 1'b0;
    nbusy = 0; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    total++;
    if (nbusy !== 0 || ndone !== 0) begin
      bad++;
      $display("FAIL clear_priority: got busy_cycles=%0d done=%0d want 0 0", nbusy, ndone);
    end
    do_op(1'b1, 32'd123456, 32'd789, 1'b0, lat, bbad, rlo, rhi, rdz);
    total++;
    if (lat !== 35 || bbad !== 0 || rlo !== 32'd156 || rhi !== 32'd372 || rdz !== 1'b0) begin
      bad++;
      $display("FAIL after_clear: got lat=%0d bl=%0d lo=%h hi=%h dz=%b want 35 0 9c 174 0",
               lat, bbad, rlo, rhi, rdz);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_back_to_back;
    test_random;
    test_clear_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
